ads131_frame_sequencer: RTL
===========================

ADS131_FRAME_SEQUENCER -- requirements
Module: ads131_frame_sequencer

Interface
REQ-001 Parameter CS_SETUP_CYC, default 4: system_clock cycles from cs_n low to entering transfer.
REQ-002 Parameter CS_HOLD_CYC, default 4: cycles from transfer end to cs_n high.
REQ-003 Parameter GAP_CYC, default 8: minimum cs_n-high cycles between frames.
REQ-004 Parameter FRAME_EDGES, default 64: final sclk_cycles value that marks a complete frame.
REQ-005 Parameter WDOG_CYC, default 2048: transfer watchdog limit in cycles.
REQ-006 system_clock  in  1: sole clock; all logic on the rising edge.
REQ-007 reset_n  in  1: asynchronous, active-low reset.
REQ-008 drdy_n  in  1: ADC data-ready, active low, asynchronous to system_clock.
REQ-009 cmd_req  in  1: host command request; held high until cmd_ack.
REQ-010 cmd_ack  out  1: one-cycle pulse when a command frame is granted.
REQ-011 sclk_cycles  in  8: edge count returned by the SCLK generator.
REQ-012 spi_state  out  5: state code to the SCLK generator; 5'd6 during transfer, 5'd0 otherwise.
REQ-013 cs_n  out  1: ADC chip select, active low.
REQ-014 frame_type  out  1: 0 = data read, 1 = command; valid while busy.
REQ-015 busy  out  1: high in every state except IDLE.
REQ-016 frame_done  out  1: one-cycle pulse on CS_HOLD to GAP.
REQ-017 wdog_err  out  1: sticky transfer-timeout flag.

Function
REQ-018 States: IDLE, CS_SETUP, XFER, CS_HOLD, GAP; one-hot or binary.
REQ-019 drdy_n passes through a 2-flop synchronizer; a DRDY event is the synchronized high-to-low edge, latched in drdy_pend.
REQ-020 IDLE: if drdy_pend, start data frame (frame_type=0) and clear drdy_pend; else if cmd_req, start command frame (frame_type=1) and pulse cmd_ack; data read has priority.
REQ-021 A DRDY edge arriving while busy sets drdy_pend; a second edge before service is dropped (no count).
REQ-022 Leaving IDLE: cs_n falls in the same cycle; CS_SETUP lasts exactly CS_SETUP_CYC cycles.
REQ-023 XFER: spi_state=6; sclk_cycles is sampled each cycle; exit to CS_HOLD when two consecutive samples both equal FRAME_EDGES.
REQ-024 sclk_cycles values other than FRAME_EDGES, including nonmonotonic glitches, do not end XFER.
REQ-025 CS_HOLD: spi_state=0; after CS_HOLD_CYC cycles cs_n rises, frame_done pulses, enter GAP.
REQ-026 GAP lasts GAP_CYC cycles with cs_n high, then IDLE; requests are latched but not granted during GAP.
REQ-027 Internal counters are 12 bits, saturating; parameters above 4095 are illegal.
REQ-028 cmd_req dropped before grant is ignored; cmd_ack never pulses twice for one frame.

Reset
REQ-029 reset_n low: state IDLE, cs_n=1, spi_state=0, busy=0, cmd_ack=0, frame_done=0, frame_type=0, wdog_err=0, drdy_pend=0, synchronizer flops=1.
REQ-030 Reset mid-frame aborts immediately; no frame_done; first frame after reset release waits for a fresh DRDY edge or cmd_req.

Configuration
REQ-031 Macro XFER_WATCHDOG_EN defined: XFER counter counts cycles; at WDOG_CYC without completion, set wdog_err, go to CS_HOLD, no frame_done pulse; wdog_err clears only on reset.
REQ-032 XFER_WATCHDOG_EN undefined: no watchdog counter; wdog_err tied 0; XFER waits indefinitely.

Verification
REQ-033 Single drdy_n low pulse, sclk_cycles ramps 0..64 -> cs_n low 4 cycles before spi_state=6, spi_state 0 two cycles after 64 seen twice, cs_n high 4 cycles later, one frame_done.
REQ-034 drdy_n edge and cmd_req in same IDLE cycle -> data frame first (frame_type=0), then command frame with cmd_ack after GAP of 8 cycles.
REQ-035 Two DRDY edges during one frame -> exactly one additional data frame.
REQ-036 sclk_cycles glitches 64 for one cycle then 30 -> XFER continues; ends only on stable 64.
REQ-037 XFER_WATCHDOG_EN, sclk_cycles stuck at 10 -> wdog_err=1 after 2048 XFER cycles, cs_n high after hold, no frame_done.
REQ-038 reset_n low during XFER -> all outputs at reset values within the same cycle, no frame_done.

Source files
------------

// File: rtl/ads131_frame_sequencer.sv
`default_nettype none
// ============================================================================
// ads131_frame_sequencer : DRDY / host-command frame sequencer for an ADS131.
// Optional macro XFER_WATCHDOG_EN adds a sticky transfer-timeout watchdog.
// Revision 1.0
// ============================================================================

module ads131_frame_sequencer #(
  parameter int CS_SETUP_CYC = 4,
  parameter int CS_HOLD_CYC  = 4,
  parameter int GAP_CYC      = 8,
  parameter int FRAME_EDGES  = 64,
  parameter int WDOG_CYC     = 2048
) (
  input  logic       system_clock,
  input  logic       reset_n,
  input  logic       drdy_n,
  input  logic       cmd_req,
  output logic       cmd_ack,
  input  logic [7:0] sclk_cycles,
  output logic [4:0] spi_state,
  output logic       cs_n,
  output logic       frame_type,
  output logic       busy,
  output logic       frame_done,
  output logic       wdog_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_XFER     = 3'd2,
    S_CS_HOLD  = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  localparam logic [11:0] SETUP_LAST = 12'(CS_SETUP_CYC - 1);
  localparam logic [11:0] HOLD_LAST  = 12'(CS_HOLD_CYC - 1);
  localparam logic [11:0] GAP_LAST   = 12'(GAP_CYC - 1);
  localparam logic [7:0]  EDGES_END  = 8'(FRAME_EDGES);
  localparam logic [4:0]  SPI_XFER   = 5'd6;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        drdy_edge;
  logic        drdy_pend_q, drdy_pend_d;
  logic        hit_q, hit_d;
  logic        grant_data, grant_cmd;
  logic        frame_end;
  logic        cs_n_q, busy_q, cmd_ack_q, frame_done_q, frame_type_q;
  logic [4:0]  spi_state_q;

`ifdef XFER_WATCHDOG_EN
  localparam logic [11:0] WDOG_LAST = 12'(WDOG_CYC - 1);
  logic wdog_trip;
  logic wdog_err_q;
  logic abort_q;
`endif

  // sync3 only delays the synchronized level so a falling edge can be seen
  assign drdy_edge   = sync3_q & ~sync2_q;
  assign drdy_pend_d = drdy_edge | (drdy_pend_q & ~grant_data);
  assign hit_d       = (state_q == S_XFER) && (sclk_cycles == EDGES_END);

  always_comb begin
    state_d    = state_q;
    grant_data = 1'b0;
    grant_cmd  = 1'b0;
`ifdef XFER_WATCHDOG_EN
    wdog_trip  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (drdy_pend_q) begin
          grant_data = 1'b1;
          state_d    = S_CS_SETUP;
        end else if (cmd_req) begin
          grant_cmd  = 1'b1;
          state_d    = S_CS_SETUP;
        end
      end
      S_CS_SETUP: if (cnt_q >= SETUP_LAST) state_d = S_XFER;
      S_XFER: begin
        if (hit_q && (sclk_cycles == EDGES_END)) begin
          state_d = S_CS_HOLD;
        end
`ifdef XFER_WATCHDOG_EN
        else if (cnt_q >= WDOG_LAST) begin
          wdog_trip = 1'b1;
          state_d   = S_CS_HOLD;
        end
`endif
      end
      S_CS_HOLD: if (cnt_q >= HOLD_LAST) state_d = S_GAP;
      S_GAP:     if (cnt_q >= GAP_LAST)  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // one shared saturating counter, restarted on every state change
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != 12'hFFF) begin
      cnt_d = cnt_q + 12'd1;
    end
  end

`ifdef XFER_WATCHDOG_EN
  assign frame_end = (state_q == S_CS_HOLD) && (state_d == S_GAP) && !abort_q;
`else
  assign frame_end = (state_q == S_CS_HOLD) && (state_d == S_GAP);
`endif

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      sync3_q      <= 1'b1;
      drdy_pend_q  <= 1'b0;
      hit_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      cmd_ack_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_type_q <= 1'b0;
      spi_state_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync1_q      <= drdy_n;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      drdy_pend_q  <= drdy_pend_d;
      hit_q        <= hit_d;
      cs_n_q       <= !((state_d == S_CS_SETUP) || (state_d == S_XFER) ||
                        (state_d == S_CS_HOLD));
      busy_q       <= (state_d != S_IDLE);
      cmd_ack_q    <= grant_cmd;
      frame_done_q <= frame_end;
      spi_state_q  <= (state_d == S_XFER) ? SPI_XFER : 5'd0;
      if (grant_data) begin
        frame_type_q <= 1'b0;
      end else if (grant_cmd) begin
        frame_type_q <= 1'b1;
      end
    end
  end

`ifdef XFER_WATCHDOG_EN
  // abort_q suppresses frame_done for the hold that follows a timeout
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_err_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      if (wdog_trip) begin
        wdog_err_q <= 1'b1;
        abort_q    <= 1'b1;
      end else if (state_q == S_IDLE) begin
        abort_q    <= 1'b0;
      end
    end
  end
  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign cmd_ack    = cmd_ack_q;
  assign frame_done = frame_done_q;
  assign frame_type = frame_type_q;
  assign spi_state  = spi_state_q;

endmodule

`default_nettype wire
